turn_banner_renderer: RTL and testbench

Reads the 80x44 turn-indicator bitmap ROM (`turn_rom`) in step with the VGA raster and outputs a registered, coloured pixel for the banner overlay. It converts raster coordinates into ROM row addresses and column bit selects, and absorbs the ROM's one-cycle address latency. It also runs a small show/blink/hide state machine driven by game events. It sits between the VGA sync generator and the final RGB mux.

---
 rtl/turn_pkg.sv | 19 +
 rtl/turn_blink_ctrl.sv | 83 ++++++++
 rtl/turn_banner_renderer.sv | 106 ++++++++++
 tb/tb_turn_banner_renderer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/turn_pkg.sv
// turn_pkg: shared constants and types for the turn-indicator banner.
//   TURN_W / TURN_H : bitmap size in ROM pixels (80 x 44)
//   COL_P0 / COL_P1 : banner colours for player 0 (red) and player 1 (blue)
//   turn_state_t    : display state of the banner controller
package turn_pkg;

  localparam int TURN_W = 80;
  localparam int TURN_H = 44;

  localparam logic [2:0] COL_P0 = 3'b100;
  localparam logic [2:0] COL_P1 = 3'b001;

  typedef enum logic [1:0] {
    HIDE  = 2'd0,
    BLINK = 2'd1,
    SHOW  = 2'd2
  } turn_state_t;

endpackage

// File: rtl/turn_blink_ctrl.sv
// turn_blink_ctrl: show / blink / hide state machine for the turn banner.
// Optional feature macro: TURN_BLINK_EN. When defined, show_turn enters
// BLINK, where visible toggles every 16 frames until BLINK_FRAMES frame
// ticks have passed, then SHOW. When undefined, show_turn goes straight to
// SHOW and frame_tick is ignored.
// Ports:
//   clk        : pixel clock
//   reset_n    : asynchronous active-low reset
//   frame_tick : one-cycle pulse per frame (start of vertical blanking)
//   show_turn  : one-cycle pulse, start (or restart) displaying the banner
//   clear_turn : one-cycle pulse, hide the banner (wins over show_turn)
//   visible    : registered display enable
module turn_blink_ctrl
  import turn_pkg::*;
#(
  parameter int BLINK_FRAMES = 120
) (
  input  logic clk,
  input  logic reset_n,
  input  logic frame_tick,
  input  logic show_turn,
  input  logic clear_turn,
  output logic visible
);

  localparam logic [7:0] LAST_FRAME = 8'(BLINK_FRAMES - 1);

  turn_state_t state_reg;

`ifdef TURN_BLINK_EN
  logic [7:0] frame_cnt_reg;
  logic [7:0] frame_cnt_inc;

  // Saturating increment: the counter never wraps while blinking.
  assign frame_cnt_inc = (frame_cnt_reg == 8'hFF) ? frame_cnt_reg
                                                  : frame_cnt_reg + 8'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= HIDE;
      frame_cnt_reg <= 8'd0;
      visible       <= 1'b0;
    end else if (clear_turn) begin
      state_reg     <= HIDE;
      frame_cnt_reg <= 8'd0;
      visible       <= 1'b0;
    end else if (show_turn) begin
      // Entering (or restarting) BLINK: count 0 has bit 4 clear -> on.
      state_reg     <= BLINK;
      frame_cnt_reg <= 8'd0;
      visible       <= 1'b1;
    end else if (state_reg == BLINK && frame_tick) begin
      if (frame_cnt_reg == LAST_FRAME) begin
        state_reg <= SHOW;
        visible   <= 1'b1;
      end else begin
        frame_cnt_reg <= frame_cnt_inc;
        // visible tracks the counter value being stored: 16 on, 16 off.
        visible       <= ~frame_cnt_inc[4];
      end
    end
  end
`else
  // Keeps frame_tick, the blink length and the state register tied off
  // in the build without blinking.
  logic unused_ctrl;
  assign unused_ctrl = ^{frame_tick, LAST_FRAME, state_reg};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= HIDE;
      visible   <= 1'b0;
    end else if (clear_turn) begin
      state_reg <= HIDE;
      visible   <= 1'b0;
    end else if (show_turn) begin
      state_reg <= SHOW;
      visible   <= 1'b1;
    end
  end
`endif

endmodule

// File: rtl/turn_banner_renderer.sv
// turn_banner_renderer: overlays the 80x44 turn-indicator bitmap on the VGA
// raster. Converts raster coordinates to a ROM row address and column bit,
// absorbs the external ROM's one-cycle read latency, and registers a
// coloured pixel (2 clocks after pixel_x / pixel_y).
// Optional feature macro: TURN_BLINK_EN (see turn_blink_ctrl).
// Parameters: X0 / Y0 banner top-left, SCALE_SH log2 scale (0 or 1),
//             BLINK_FRAMES frames spent blinking before steady SHOW.
// Ports:
//   clk, reset_n                 : pixel clock, async active-low reset
//   pixel_x, pixel_y, video_on   : raster position and active-area flag
//   frame_tick                   : per-frame pulse
//   show_turn, clear_turn        : banner commands
//   player                       : colour select (0 red, 1 blue)
//   rom_addr                     : combinational row address to turn_rom
//   rom_data                     : row data from turn_rom (bit 79 = leftmost)
//   pixel_on, rgb                : registered banner pixel and colour
//   visible                      : display enable from the controller
module turn_banner_renderer
  import turn_pkg::*;
#(
  parameter int X0           = 280,
  parameter int Y0           = 200,
  parameter int SCALE_SH     = 0,
  parameter int BLINK_FRAMES = 120
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        video_on,
  input  logic        frame_tick,
  input  logic        show_turn,
  input  logic        clear_turn,
  input  logic        player,
  output logic [5:0]  rom_addr,
  input  logic [79:0] rom_data,
  output logic        pixel_on,
  output logic [2:0]  rgb,
  output logic        visible
);

  localparam logic [9:0] X0_V = 10'(X0);
  localparam logic [9:0] Y0_V = 10'(Y0);

  logic [9:0] dx, dy, dx_s, dy_s;
  logic       in_region;
  logic [6:0] col_next;

  logic [6:0] col1_reg;
  logic       inreg1_reg;
  logic       player1_reg;
  logic       pixel_on_next;
  logic [2:0] rgb_next;

  // Offsets wrap when left of / above the banner; the >= tests reject those.
  assign dx   = pixel_x - X0_V;
  assign dy   = pixel_y - Y0_V;
  assign dx_s = dx >> SCALE_SH;
  assign dy_s = dy >> SCALE_SH;

  assign in_region = (pixel_x >= X0_V) && (pixel_y >= Y0_V) &&
                     (dx_s < 10'(TURN_W)) && (dy_s < 10'(TURN_H));

  // Out-of-region rows are parked at 0 so the ROM never sees 0x2C-0x3F.
  assign rom_addr = in_region ? dy_s[5:0] : 6'd0;
  assign col_next = in_region ? 7'(7'd79 - dx_s[6:0]) : 7'd0;

  // Stage 1 runs alongside the ROM's internal address register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col1_reg    <= 7'd0;
      inreg1_reg  <= 1'b0;
      player1_reg <= 1'b0;
    end else begin
      col1_reg    <= col_next;
      inreg1_reg  <= in_region & video_on;
      player1_reg <= player;
    end
  end

  assign pixel_on_next = inreg1_reg & rom_data[col1_reg] & visible;
  assign rgb_next      = pixel_on_next ? (player1_reg ? COL_P1 : COL_P0)
                                       : 3'b000;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pixel_on <= 1'b0;
      rgb      <= 3'b000;
    end else begin
      pixel_on <= pixel_on_next;
      rgb      <= rgb_next;
    end
  end

  turn_blink_ctrl #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_ctrl (
    .clk       (clk),
    .reset_n   (reset_n),
    .frame_tick(frame_tick),
    .show_turn (show_turn),
    .clear_turn(clear_turn),
    .visible   (visible)
  );

endmodule

// File: tb/tb_turn_banner_renderer.sv
// Bench for turn_banner_renderer: a 1x instance (dut_a) and a 2x instance
// (dut_b) share the raster and command inputs, each with its own
// registered-read ROM model. ROM contents: a diagonal (row r lights bit
// 79-r) plus row 5 bit 68.
module tb_turn_banner_renderer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [9:0]  pixel_x = '0;
  logic [9:0]  pixel_y = '0;
  logic        video_on = 1'b0;
  logic        frame_tick = 1'b0;
  logic        show_turn = 1'b0;
  logic        clear_turn = 1'b0;
  logic        player = 1'b0;

  logic [5:0]  rom_addr_a, rom_addr_b;
  logic [79:0] rom_data_a = '0;
  logic [79:0] rom_data_b = '0;
  logic        pixel_on_a, pixel_on_b, visible_a, visible_b;
  logic [2:0]  rgb_a, rgb_b;

  logic [79:0] rom [0:43];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  turn_banner_renderer dut_a (
    .clk(clk), .reset_n(reset_n), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .frame_tick(frame_tick), .show_turn(show_turn),
    .clear_turn(clear_turn), .player(player), .rom_addr(rom_addr_a),
    .rom_data(rom_data_a), .pixel_on(pixel_on_a), .rgb(rgb_a),
    .visible(visible_a)
  );

  turn_banner_renderer #(.SCALE_SH(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .frame_tick(frame_tick), .show_turn(show_turn),
    .clear_turn(clear_turn), .player(player), .rom_addr(rom_addr_b),
    .rom_data(rom_data_b), .pixel_on(pixel_on_b), .rgb(rgb_b),
    .visible(visible_b)
  );

  // ROM models: registered read, out-of-range rows read as zero.
  always @(posedge clk) begin
    rom_data_a <= (rom_addr_a < 6'd44) ? rom[rom_addr_a] : '0;
    rom_data_b <= (rom_addr_b < 6'd44) ? rom[rom_addr_b] : '0;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Present a raster position and wait the 2-clock pipeline latency.
  task automatic apply_pixel(input int x, input int y, input logic von);
    @(negedge clk);
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    video_on = von;
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_show();
    @(negedge clk); show_turn = 1'b1;
    @(negedge clk); show_turn = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk); clear_turn = 1'b1;
    @(negedge clk); clear_turn = 1'b0;
  endtask

  task automatic pulse_both();
    @(negedge clk); show_turn = 1'b1; clear_turn = 1'b1;
    @(negedge clk); show_turn = 1'b0; clear_turn = 1'b0;
  endtask

  task automatic pulse_tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); frame_tick = 1'b1;
      @(negedge clk); frame_tick = 1'b0;
    end
  endtask

  initial begin
    logic [5:0] max_a, max_b;

    for (int r = 0; r < 44; r++) begin
      rom[r] = '0;
      rom[r][79 - r] = 1'b1;
    end
    rom[5][68] = 1'b1;

    // Reset
    #2 reset_n = 1'b0;
    #1;
    check_eq("reset_pixel_on", 32'(pixel_on_a), 32'd0);
    check_eq("reset_rgb",      32'(rgb_a),      32'd0);
    check_eq("reset_visible",  32'(visible_a),  32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Lit ROM pixel stays dark while hidden
    apply_pixel(291, 205, 1'b1);
    check_eq("hidden_pixel_on", 32'(pixel_on_a), 32'd0);
    check_eq("hidden_rom_addr", 32'(rom_addr_a), 32'd5);

    pulse_show();
    check_eq("show_visible", 32'(visible_a), 32'd1);

    // Pixel lookup, 1x
    player = 1'b0;
    apply_pixel(291, 205, 1'b1);
    check_eq("lookup_291_205_on",  32'(pixel_on_a), 32'd1);
    check_eq("lookup_291_205_rgb", 32'(rgb_a),      32'd4);
    apply_pixel(290, 205, 1'b1);
    check_eq("lookup_290_205_on",  32'(pixel_on_a), 32'd0);
    check_eq("lookup_290_205_rgb", 32'(rgb_a),      32'd0);
    apply_pixel(290, 210, 1'b1);
    check_eq("lookup_290_210_on",  32'(pixel_on_a), 32'd1);
    check_eq("lookup_290_210_addr", 32'(rom_addr_a), 32'd10);
    player = 1'b1;
    apply_pixel(291, 205, 1'b1);
    check_eq("player1_rgb", 32'(rgb_a), 32'd1);
    player = 1'b0;
    apply_pixel(291, 205, 1'b0);
    check_eq("video_off_on", 32'(pixel_on_a), 32'd0);

    // Out of region
    apply_pixel(279, 210, 1'b1);
    check_eq("oor_279_210_on",   32'(pixel_on_a), 32'd0);
    check_eq("oor_279_210_addr", 32'(rom_addr_a), 32'd0);
    apply_pixel(360, 210, 1'b1);
    check_eq("oor_360_210_on",   32'(pixel_on_a), 32'd0);
    check_eq("oor_360_210_addr", 32'(rom_addr_a), 32'd0);
    apply_pixel(300, 244, 1'b1);
    check_eq("oor_300_244_on",   32'(pixel_on_a), 32'd0);
    check_eq("oor_300_244_addr", 32'(rom_addr_a), 32'd0);
    apply_pixel(359, 243, 1'b1);
    check_eq("corner_359_243_addr", 32'(rom_addr_a), 32'd43);

    // Scale 2x
    apply_pixel(302, 210, 1'b1);
    check_eq("x2_302_210_on",   32'(pixel_on_b), 32'd1);
    check_eq("x2_302_210_addr", 32'(rom_addr_b), 32'd5);
    apply_pixel(303, 211, 1'b1);
    check_eq("x2_303_211_on",   32'(pixel_on_b), 32'd1);
    check_eq("x2_303_211_addr", 32'(rom_addr_b), 32'd5);
    apply_pixel(301, 210, 1'b1);
    check_eq("x2_301_210_on",   32'(pixel_on_b), 32'd0);

    // Full-frame sweep of the combinational row address
    max_a = '0;
    max_b = '0;
    for (int y = 0; y < 480; y++) begin
      for (int x = 0; x < 640; x++) begin
        pixel_x = 10'(x);
        pixel_y = 10'(y);
        #1;
        if (rom_addr_a > max_a) max_a = rom_addr_a;
        if (rom_addr_b > max_b) max_b = rom_addr_b;
      end
    end
    check_eq("sweep_max_addr_1x", 32'(max_a), 32'd43);
    check_eq("sweep_max_addr_2x", 32'(max_b), 32'd43);

    // Command priority
    pulse_both();
    check_eq("both_visible", 32'(visible_a), 32'd0);
    apply_pixel(291, 205, 1'b1);
    check_eq("both_pixel_on", 32'(pixel_on_a), 32'd0);
    pulse_show();
    pulse_clear();
    check_eq("clear_visible", 32'(visible_a), 32'd0);

`ifdef TURN_BLINK_EN
    pulse_show();
    check_eq("blink_f0", 32'(visible_a), 32'd1);
    pulse_tick(15);
    check_eq("blink_f15", 32'(visible_a), 32'd1);
    pulse_tick(1);
    check_eq("blink_f16", 32'(visible_a), 32'd0);
    pulse_tick(15);
    check_eq("blink_f31", 32'(visible_a), 32'd0);
    pulse_tick(1);
    check_eq("blink_f32", 32'(visible_a), 32'd1);
    pulse_tick(87);
    check_eq("blink_f119", 32'(visible_a), 32'd0);
    pulse_tick(1);
    check_eq("blink_show", 32'(visible_a), 32'd1);
    pulse_tick(40);
    check_eq("show_holds", 32'(visible_a), 32'd1);
    pulse_show();
    pulse_tick(16);
    check_eq("reblink_f16", 32'(visible_a), 32'd0);
`else
    pulse_show();
    check_eq("direct_show", 32'(visible_a), 32'd1);
    pulse_tick(20);
    check_eq("tick_ignored", 32'(visible_a), 32'd1);
`endif

    // Reset mid-frame
    pulse_show();
    pulse_tick(1);
    apply_pixel(291, 205, 1'b1);
    check_eq("prereset_pixel_on", 32'(pixel_on_a), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("async_pixel_on", 32'(pixel_on_a), 32'd0);
    check_eq("async_rgb",      32'(rgb_a),      32'd0);
    check_eq("async_visible",  32'(visible_a),  32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("postreset_visible",  32'(visible_a),  32'd0);
    check_eq("postreset_pixel_on", 32'(pixel_on_a), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
